// File: rtl/piso_serial_tx_pkg.sv
// piso_serial_tx_pkg: shared state encoding, idle line level and counter-width helper
package piso_serial_tx_pkg;

  typedef logic state_t;

  localparam state_t IDLE       = 1'b0;
  localparam state_t SHIFT      = 1'b1;
  localparam logic   IDLE_LEVEL = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// tx_bit_counter: loadable down-counter with zero flag, saturating at zero
module tx_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign zero_o = cnt_q == '0;
  assign cnt_o  = cnt_q;

  // next count: load wins, otherwise step down until zero and park there
  always_comb begin
    cnt_d = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
  end

  // count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_serial_tx.sv
// piso_serial_tx: parallel-in/serial-out transmitter, one WIDTH-bit frame per accepted word
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
  logic [CW-1:0]    cnt;
  logic             cnt_zero, busy, accept;

  assign busy       = state_q == SHIFT;
  assign load_ready = !busy || cnt_zero;
  assign accept     = load_valid && load_ready;
  assign shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  tx_bit_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept),
    .load_val_i (LAST_IDX),
    .dec_i      (busy && !accept),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // an accept in the last-bit cycle reloads directly, keeping frames gapless
  always_comb begin
    state_d = accept ? SHIFT : (busy && cnt_zero) ? IDLE : state_q;
    shreg_d = accept ? data_in : busy ? shifted : shreg_q;
  end

  // state and shift chain, cleared asynchronously so a reset aborts the frame at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign ser_valid   = busy;
  assign frame_start = busy && cnt == LAST_IDX;
  assign done        = busy && cnt_zero;
  assign ser_out     = busy ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serial_tx.sv
// tb_piso_serial_tx: scoreboard bench for MSB-first and LSB-first transmitters
module tb_piso_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       r0, so0, sv0, fs0, dn0;
  logic       r1, so1, sv1, fs1, dn1;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] e0, e1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .load_valid(v0), .load_ready(r0),
    .ser_out(so0), .ser_valid(sv0), .frame_start(fs0), .done(dn0)
  );

  piso_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(d1), .load_valid(v1), .load_ready(r1),
    .ser_out(so1), .ser_valid(sv1), .frame_start(fs1), .done(dn1)
  );

  // monitor: every valid serial bit must match the head of its scoreboard queue as {bit,frame_start,done}
  always @(negedge clk) begin
    if (rst_n) begin
      if (sv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL msb_unexpected_bit got {ser,fs,done}=%03b required no valid bit", {so0, fs0, dn0});
        end else begin
          e0 = q0.pop_front();
          if ({so0, fs0, dn0} !== e0) begin
            errors++;
            $display("FAIL msb_bit got {ser,fs,done}=%03b required %03b", {so0, fs0, dn0}, e0);
          end
        end
      end
      if (sv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL lsb_unexpected_bit got {ser,fs,done}=%03b required no valid bit", {so1, fs1, dn1});
        end else begin
          e1 = q1.pop_front();
          if ({so1, fs1, dn1} !== e1) begin
            errors++;
            $display("FAIL lsb_bit got {ser,fs,done}=%03b required %03b", {so1, fs1, dn1}, e1);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // present w to DUT s and wait (bounded) for it to be accepted; expected bits are queued on accept
  task automatic put(input int s, input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    if (s == 0) begin d0 = w; v0 = 1'b1; end
    else        begin d1 = w; v1 = 1'b1; end
    while (!(s == 0 ? r0 : r1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {7'd0, (s == 0 ? r0 : r1)}, 8'd1);
    if (s == 0 ? r0 : r1)
      for (int i = 0; i < 8; i++) begin
        if (s == 0) q0.push_back({w[7-i], i == 0, i == 7});
        else        q1.push_back({w[i], i == 0, i == 7});
      end
    @(posedge clk);
  endtask

  task automatic rel(input int s);
    @(negedge clk);
    if (s == 0) v0 = 1'b0;
    else        v1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 8'(q0.size() + q1.size()), 8'd0);
    @(negedge clk);
    check("idle_after_frame", {5'd0, so0, sv0, r0}, 8'b001);
    check("idle_after_frame_lsb", {5'd0, so1, sv1, r1}, 8'b001);
  endtask

  initial begin
    rst_n = 1'b0;
    d0 = 8'h00; d1 = 8'h00; v0 = 1'b0; v1 = 1'b0;
    #1;
    check("reset_msb", {3'd0, so0, sv0, fs0, dn0, r0}, 8'b00001);
    check("reset_lsb", {3'd0, so1, sv1, fs1, dn1, r1}, 8'b00001);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // single frame A5, MSB first
    put(0, 8'hA5);
    rel(0);
    drain();

    // back-to-back A5 then 3C; second accept lands in the done cycle
    put(0, 8'hA5);
    put(0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) v0 = 1'b0;
      check("b2b_valid", {7'd0, sv0}, 8'd1);
    end
    drain();

    // LSB first: 01 then 80
    put(1, 8'h01);
    rel(1);
    drain();
    put(1, 8'h80);
    rel(1);
    drain();

    // mid-frame load attempt during F0 is ignored
    put(0, 8'hF0);
    @(negedge clk) v0 = 1'b0;
    repeat (2) @(negedge clk);
    d0 = 8'h0F;
    v0 = 1'b1;
    check("mid_frame_ready", {7'd0, r0}, 8'd0);
    @(negedge clk) v0 = 1'b0;
    drain();

    // asynchronous reset during bit 4 of FF
    put(0, 8'hFF);
    @(negedge clk) v0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {3'd0, so0, sv0, fs0, dn0, r0}, 8'b00001);
    q0.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {6'd0, sv0, dn0}, 8'd0);
    end
    put(0, 8'h81);
    rel(0);
    drain();

    // idle stability
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_stable", {5'd0, so0, sv0, r0}, 8'b001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
